// File: rtl/png_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : png_pkg
//  Description : Shared constants and FSM state encoding for the PNG IDAT
//                chunk packer. The IEND states/constants exist only when
//                IDAT_CHUNK_PACK_IEND_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package png_pkg;

    localparam int unsigned ST_W = 4;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_LEN   = 4'd1;
    localparam state_t ST_TYPE  = 4'd2;
    localparam state_t ST_DATA  = 4'd3;
    localparam state_t ST_CRC   = 4'd4;
    localparam state_t ST_END   = 4'd5;
`ifdef IDAT_CHUNK_PACK_IEND_EN
    localparam state_t ST_IEND0 = 4'd6;
    localparam state_t ST_IEND1 = 4'd7;
    localparam state_t ST_IEND2 = 4'd8;

    localparam logic [31:0] IEND_TYPE = 32'h49454E44;
    localparam logic [31:0] IEND_CRC  = 32'hAE426082;
`endif

    localparam logic [31:0] IDAT_TYPE = 32'h49444154;
    localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;

endpackage : png_pkg
`default_nettype wire

// File: rtl/idat_chunk_pack_if.sv
`default_nettype none
// ============================================================================
//  Interface   : idat_chunk_pack_if
//  Description : Stream-in / PNG-word-out bundle of the IDAT chunk packer.
//                master = upstream/file-writer side, slave = packer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface idat_chunk_pack_if;

    logic        val_i;
    logic [31:0] dat_i;
    logic        done_i;
    logic        val_o;
    logic [31:0] dat_o;
    logic        done_o;
    logic        err_o;

    modport master (
        output val_i, dat_i, done_i,
        input  val_o, dat_o, done_o, err_o
    );

    modport slave (
        input  val_i, dat_i, done_i,
        output val_o, dat_o, done_o, err_o
    );

endinterface : idat_chunk_pack_if
`default_nettype wire

// File: rtl/crc32_word.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_word
//  Description : Combinational reflected CRC-32 update over one 32-bit word,
//                most significant byte first (PNG byte order).
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_word
    import png_pkg::*;
(
    input  wire  [31:0] crc_i,
    input  wire  [31:0] word_i,
    output logic [31:0] crc_o
);

    logic [31:0] acc;

    // Four byte steps, eight LSB-first bit steps each
    always_comb begin
        acc = crc_i;
        for (int b = 3; b >= 0; b--) begin
            acc = acc ^ {24'd0, word_i[b*8 +: 8]};
            for (int k = 0; k < 8; k++) begin
                acc = acc[0] ? ((acc >> 1) ^ CRC_POLY) : (acc >> 1);
            end
        end
        crc_o = acc;
    end

endmodule : crc32_word
`default_nettype wire

// File: rtl/idat_chunk_pack.sv
`default_nettype none
// ============================================================================
//  Module      : idat_chunk_pack
//  Description : Wraps a zlib word stream into PNG IDAT chunks
//                (length, "IDAT", payload, CRC-32) as big-endian words.
//                Payload is buffered in a word FIFO so the length can lead.
//                Optional macro IDAT_CHUNK_PACK_IEND_EN appends an IEND chunk
//                after the final IDAT chunk.
//  Revision    : 1.0 - initial release
// ============================================================================
module idat_chunk_pack
    import png_pkg::*;
#(
    parameter int unsigned FIFO_AW     = 5,
    parameter int unsigned CHUNK_WORDS = 16   // 1 .. 2**FIFO_AW
) (
    input wire               clk,
    input wire               rst,
    idat_chunk_pack_if.slave bus
);

    localparam int unsigned       DEPTH   = 1 << FIFO_AW;
    localparam int unsigned       CNT_W   = FIFO_AW + 1;
    localparam logic [CNT_W-1:0]  CHUNK_N = CNT_W'(CHUNK_WORDS);
    localparam logic [CNT_W-1:0]  FULL_N  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    // FIFO storage and bookkeeping
    logic [31:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               done_pend_q;
    logic               err_q;

    // Chunk FSM
    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   n_q,      n_d;
    logic [CNT_W-1:0]   beat_q,   beat_d;
    logic               last_q,   last_d;
    logic [31:0]        crc_q,    crc_d;

    logic [31:0]        crc_nxt;
    logic [31:0]        rd_word;
    logic [31:0]        out_word;
    logic               out_val;
    logic               out_done;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               start;

    assign full    = (count_q == FULL_N);
    assign pop     = (state_q == ST_DATA);
    // A pop in the same cycle frees the slot the push lands in
    assign push_ok = bus.val_i && (!full || pop);
    assign rd_word = mem_q[rd_ptr_q];
    assign start   = (count_q >= CHUNK_N) || (done_pend_q && (count_q != '0));

    // FIFO storage write, input bytes reversed into PNG order
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {bus.dat_i[7:0], bus.dat_i[15:8],
                                bus.dat_i[23:16], bus.dat_i[31:24]};
        end
    end

    // FIFO pointers, occupancy, end-of-stream and overflow flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (bus.val_i && full && !pop) err_q <= 1'b1;
            if (bus.val_i && bus.done_i) begin
                done_pend_q <= 1'b1;
            end else if (state_q == ST_END) begin
                done_pend_q <= 1'b0;
            end
        end
    end

    // FSM state and per-chunk context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
            crc_q   <= CRC_INIT;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            crc_q   <= crc_d;
        end
    end

    // Next-state: chunk sequencing, size latch and running CRC
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        beat_d  = beat_q;
        last_d  = last_q;
        crc_d   = crc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEN;
                    n_d     = (count_q >= CHUNK_N) ? CHUNK_N : count_q;
                    last_d  = done_pend_q && (count_q <= CHUNK_N);
                end
            end
            ST_LEN: begin
                state_d = ST_TYPE;
                crc_d   = CRC_INIT;
                beat_d  = '0;
            end
            ST_TYPE: begin
                state_d = ST_DATA;
                crc_d   = crc_nxt;
            end
            ST_DATA: begin
                crc_d  = crc_nxt;
                beat_d = beat_q + CNT_ONE;
                if (beat_q == (n_q - CNT_ONE)) state_d = ST_CRC;
            end
            ST_CRC: begin
`ifdef IDAT_CHUNK_PACK_IEND_EN
                state_d = last_q ? ST_IEND0 : ST_IDLE;
`else
                state_d = last_q ? ST_END : ST_IDLE;
`endif
            end
`ifdef IDAT_CHUNK_PACK_IEND_EN
            ST_IEND0: state_d = ST_IEND1;
            ST_IEND1: state_d = ST_IEND2;
            ST_IEND2: state_d = ST_END;
`endif
            ST_END:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; idle/reset drives all zeros
    always_comb begin
        out_val  = 1'b0;
        out_word = '0;
        out_done = 1'b0;
        case (state_q)
            ST_LEN: begin
                out_val  = 1'b1;
                out_word = 32'({n_q, 2'b00});
            end
            ST_TYPE: begin
                out_val  = 1'b1;
                out_word = IDAT_TYPE;
            end
            ST_DATA: begin
                out_val  = 1'b1;
                out_word = rd_word;
            end
            ST_CRC: begin
                out_val  = 1'b1;
                out_word = ~crc_q;
            end
`ifdef IDAT_CHUNK_PACK_IEND_EN
            ST_IEND0: begin
                out_val  = 1'b1;
                out_word = 32'h00000000;
            end
            ST_IEND1: begin
                out_val  = 1'b1;
                out_word = IEND_TYPE;
            end
            ST_IEND2: begin
                out_val  = 1'b1;
                out_word = IEND_CRC;
            end
`endif
            ST_END:   out_done = 1'b1;
            default: begin
                out_val  = 1'b0;
            end
        endcase
    end

    // CRC runs over exactly the word being emitted (TYPE and DATA states)
    crc32_word u_crc32_word (
        .crc_i  (crc_q),
        .word_i (out_word),
        .crc_o  (crc_nxt)
    );

    assign bus.val_o  = out_val;
    assign bus.dat_o  = out_word;
    assign bus.done_o = out_done;
    assign bus.err_o  = err_q;

endmodule : idat_chunk_pack
`default_nettype wire

// File: tb/tb_idat_chunk_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idat_chunk_pack
//  Description : Self-checking bench for idat_chunk_pack. A stream-level model
//                splits pushed words into chunks of CW words (remainder on
//                end of stream) and builds the expected PNG words and CRCs.
//                Honours IDAT_CHUNK_PACK_IEND_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idat_chunk_pack;

    localparam int CW = 4;
`ifdef IDAT_CHUNK_PACK_IEND_EN
    localparam bit IEND = 1'b1;
`else
    localparam bit IEND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic orst = 1'b1;
    always #5 clk = ~clk;

    idat_chunk_pack_if bus();
    idat_chunk_pack_if obus();

    idat_chunk_pack #(.FIFO_AW(5), .CHUNK_WORDS(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    idat_chunk_pack #(.FIFO_AW(2), .CHUNK_WORDS(4)) dut_ovf (
        .clk (clk),
        .rst (orst),
        .bus (obus)
    );

    logic [31:0] u_crc_o;
    crc32_word u_crc (
        .crc_i  (32'hFFFFFFFF),
        .word_i (32'h49444154),
        .crc_o  (u_crc_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] w;
        bit          start;
        bit          fin;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] pend[$];
    logic [31:0] obs_log[$];
    logic [31:0] len_log[$];
    bit          want_done = 1'b0;
    int          dones = 0;
    exp_t        e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Standard reflected CRC-32 over a byte sequence
    function automatic logic [31:0] ref_crc(input logic [7:0] by[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (by[i]) begin
            c ^= {24'd0, by[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Turn every pending word into one expected chunk
    task automatic emit_chunk(input bit last);
        logic [7:0]  by[$];
        logic [31:0] be;
        int          n;
        n  = pend.size();
        by = '{8'h49, 8'h44, 8'h41, 8'h54};
        expq.push_back('{w: 32'(n * 4), start: 1'b1, fin: 1'b0});
        expq.push_back('{w: 32'h49444154, start: 1'b0, fin: 1'b0});
        for (int i = 0; i < n; i++) begin
            be = bswap(pend.pop_front());
            expq.push_back('{w: be, start: 1'b0, fin: 1'b0});
            for (int b = 3; b >= 0; b--) by.push_back(be[b*8 +: 8]);
        end
        expq.push_back('{w: ref_crc(by), start: 1'b0, fin: last && !IEND});
        if (last && IEND) begin
            expq.push_back('{w: 32'h00000000, start: 1'b0, fin: 1'b0});
            expq.push_back('{w: 32'h49454E44, start: 1'b0, fin: 1'b0});
            expq.push_back('{w: 32'hAE426082, start: 1'b0, fin: 1'b1});
        end
    endtask

    // One word into the main DUT for one cycle; model updated up front
    task automatic push(input logic [31:0] w, input bit d);
        bus.val_i  = 1'b1;
        bus.dat_i  = w;
        bus.done_i = d;
        pend.push_back(w);
        if (d) emit_chunk(1'b1);
        else if (pend.size() == CW) emit_chunk(1'b0);
        @(negedge clk);
        bus.val_i  = 1'b0;
        bus.done_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (expq.size() > 0 || want_done); i++) @(negedge clk);
        check("drain_timeout", 32'(expq.size() == 0 && !want_done), 32'd1);
        @(negedge clk);
    endtask

    // Output monitor: words in order, no gaps inside a chunk, done_o placement
    always @(negedge clk) begin
        if (rst) begin
            want_done = 1'b0;
        end else begin
            check("done_o", 32'(bus.done_o), 32'(want_done));
            if (bus.done_o) dones++;
            want_done = 1'b0;
            if (bus.val_o) begin
                obs_log.push_back(bus.dat_o);
                if (expq.size() == 0) begin
                    check("val_o_unexpected", 32'(bus.val_o), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("dat_o", bus.dat_o, e.w);
                    if (e.start) len_log.push_back(bus.dat_o);
                    want_done = e.fin;
                end
            end else if (expq.size() > 0 && !expq[0].start) begin
                check("val_o_gap", 32'(bus.val_o), 32'd1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int nw;
        logic [7:0] idat_by[$];
        bus.val_i = 1'b0; bus.dat_i = '0; bus.done_i = 1'b0;
        obus.val_i = 1'b0; obus.dat_i = '0; obus.done_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_val_o",  32'(bus.val_o),  32'd0);
        check("rst_dat_o",  bus.dat_o,       32'd0);
        check("rst_done_o", 32'(bus.done_o), 32'd0);
        check("rst_err_o",  32'(bus.err_o),  32'd0);
        check("rst_ovf_val_o", 32'(obus.val_o), 32'd0);

        // CRC of an empty IDAT chunk
        check("crc32_word_idat", ~u_crc_o, 32'h35AF061E);
        idat_by = '{8'h49, 8'h44, 8'h41, 8'h54};
        check("model_crc_idat", ref_crc(idat_by), 32'h35AF061E);

        rst = 1'b0;
        orst = 1'b0;
        @(negedge clk);

        // Single word with end of stream, plus LEN latency
        obs_log = {};
        push(32'hA1B2C3D4, 1'b1);
        check("lat_cond_cycle_val_o", 32'(bus.val_o), 32'd0);
        @(negedge clk);
        check("lat_len_val_o", 32'(bus.val_o), 32'd1);
        check("lat_len_dat_o", bus.dat_o, 32'h00000004);
        drain();
        check("single_data", obs_log[2], 32'hD4C3B2A1);
`ifdef IDAT_CHUNK_PACK_IEND_EN
        check("single_iend0", obs_log[4], 32'h00000000);
        check("single_iend1", obs_log[5], 32'h49454E44);
        check("single_iend2", obs_log[6], 32'hAE426082);
`endif

        // Four words, one full final chunk
        obs_log = {};
        push(32'h44332211, 1'b0); @(negedge clk);
        push(32'h88776655, 1'b0); @(negedge clk);
        push(32'hCCBBAA99, 1'b0); @(negedge clk);
        push(32'h00FFEEDD, 1'b1);
        drain();
        check("a_len",  obs_log[0], 32'h00000010);
        check("a_type", obs_log[1], 32'h49444154);
        check("a_d0",   obs_log[2], 32'h11223344);
        check("a_d1",   obs_log[3], 32'h55667788);
        check("a_d2",   obs_log[4], 32'h99AABBCC);
        check("a_d3",   obs_log[5], 32'hDDEEFF00);

        // Ten words every second cycle: 4 + 4 + 2
        len_log = {};
        d0 = dones;
        for (int i = 0; i < 10; i++) begin
            push(32'h5A000000 + 32'(i * 32'h01010101), i == 9);
            @(negedge clk);
        end
        drain();
        check("b_nchunks", 32'(len_log.size()), 32'd3);
        check("b_len0", len_log[0], 32'h00000010);
        check("b_len1", len_log[1], 32'h00000010);
        check("b_len2", len_log[2], 32'h00000008);
        check("b_dones", 32'(dones - d0), 32'd1);

        // Random streams at no more than one word per two cycles
        for (int s = 0; s < 6; s++) begin
            nw = int'($urandom_range(1, 13));
            for (int i = 0; i < nw; i++) begin
                push($urandom, i == nw - 1);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            drain();
        end
        check("main_err_o", 32'(bus.err_o), 32'd0);

        // Overflow on the 4-deep instance: push every cycle
        for (int i = 0; i < 5; i++) begin
            obus.val_i = 1'b1;
            obus.dat_i = 32'h0A0B0C00 + 32'(i);
            @(negedge clk);
            if (i == 3) check("ovf_err_before_drop", 32'(obus.err_o), 32'd0);
        end
        check("ovf_err_first_drop", 32'(obus.err_o), 32'd1);
        check("ovf_len", obus.dat_o, 32'h00000010);
        @(negedge clk);
        check("ovf_type", obus.dat_o, 32'h49444154);
        check("ovf_err_sticky", 32'(obus.err_o), 32'd1);
        @(negedge clk);
        obus.val_i = 1'b0;
        check("ovf_data0_val", 32'(obus.val_o), 32'd1);
        check("ovf_data0", obus.dat_o, 32'h000C0B0A);

        // Asynchronous reset mid-DATA
        #2 orst = 1'b1;
        #1;
        check("arst_val_o", 32'(obus.val_o), 32'd0);
        check("arst_err_o", 32'(obus.err_o), 32'd0);
        check("arst_dat_o", obus.dat_o, 32'd0);
        @(negedge clk);
        orst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(obus.val_o), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_idat_chunk_pack
`default_nettype wire
